// File: rtl/fft_frame_aligner.sv
// Frames an arbitrary-length AXI-Stream sample stream into FFT_LEN-sample frames,
// zero-padding any frame that a host tlast cuts short.
module fft_frame_aligner #(
    parameter int unsigned FFT_LEN = 1024,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       pad_cnt,
    output logic              busy
);
    localparam int unsigned      IDX_W    = $clog2(FFT_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FFT_LEN - 1);

    typedef enum logic {
        ST_PASS = 1'b0,
        ST_PAD  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [15:0]       pad_cnt_q, pad_cnt_d;
    logic              busy_q, busy_d;

    logic             out_hs;
    logic             out_free;
    logic             in_hs;
    logic [IDX_W-1:0] pos_next;

    assign out_hs        = valid_q && m_axis_tready;
    assign out_free      = !valid_q || m_axis_tready;
    assign s_axis_tready = (state_q == ST_PASS) && out_free;
    assign in_hs         = s_axis_tvalid && s_axis_tready;
    // Frame position of whatever gets loaded into the output register this cycle.
    assign pos_next      = out_hs ? idx_q + IDX_W'(1) : idx_q;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;
        idx_d       = pos_next;
        frame_cnt_d = frame_cnt_q;
        pad_cnt_d   = pad_cnt_q;

        if (out_hs) begin
            valid_d = 1'b0;
        end
        if (out_hs && last_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end

        case (state_q)
            ST_PASS: begin
                if (in_hs) begin
                    data_d  = s_axis_tdata;
                    valid_d = 1'b1;
                    last_d  = (pos_next == IDX_LAST);
                    if (s_axis_tlast && (pos_next != IDX_LAST)) begin
                        state_d   = ST_PAD;
                        pad_cnt_d = pad_cnt_q + 16'd1;
                    end
                end
            end
            ST_PAD: begin
                // Once the closing zero is loaded, wait for its handshake before resuming.
                if (valid_q && last_q) begin
                    if (out_hs) begin
                        state_d = ST_PASS;
                    end
                end else if (out_free) begin
                    data_d  = '0;
                    valid_d = 1'b1;
                    last_d  = (pos_next == IDX_LAST);
                end
            end
            default: state_d = ST_PASS;
        endcase

        busy_d = (idx_d != '0) || valid_d;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= ST_PASS;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            idx_q       <= '0;
            frame_cnt_q <= '0;
            pad_cnt_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            pad_cnt_q   <= pad_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = valid_q;
    assign m_axis_tlast  = last_q;
    assign frame_cnt     = frame_cnt_q;
    assign pad_cnt       = pad_cnt_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_fft_frame_aligner.sv
// Bench for fft_frame_aligner at FFT_LEN=8: table of transfers, corner-case
// sequences and random transfers, all checked against a frame-rounding model.
module tb_fft_frame_aligner;
    localparam int N  = 8;
    localparam int DW = 32;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [15:0]   frame_cnt;
    logic [15:0]   pad_cnt;
    logic          busy;

    fft_frame_aligner #(.FFT_LEN(N), .DATA_W(DW)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .frame_cnt     (frame_cnt),
        .pad_cnt       (pad_cnt),
        .busy          (busy)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        int          len;
        logic [31:0] base;
        int          exp_frames;
        int          exp_pads;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    int          rdy_mode = 1;   // 0 random, 1 high, 2 low
    beat_t       got_q[$];
    beat_t       exp_q[$];
    int unsigned hs_cyc_q[$];
    logic [15:0] m_frames = 16'd0;
    logic [15:0] m_pads   = 16'd0;

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    // Downstream ready generator; sole driver of m_axis_tready.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            case (rdy_mode)
                0:       m_axis_tready = ($urandom_range(0, 3) != 0);
                1:       m_axis_tready = 1'b1;
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    // Mid-cycle monitor: records output handshakes and checks AXI hold under stall.
    initial begin
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk_eq("hold valid", 32'(m_axis_tvalid), 32'd1);
                    chk_eq("hold data", m_axis_tdata, prev_data);
                    chk_eq("hold last", 32'(m_axis_tlast), 32'(prev_last));
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    got_q.push_back({m_axis_tdata, m_axis_tlast});
                    hs_cyc_q.push_back(cyc);
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_data  = m_axis_tdata;
                prev_last  = m_axis_tlast;
            end
        end
    end

    // Reference: a transfer of len samples is rounded up to whole frames with zeros.
    task automatic model_transfer(input int len, input logic [31:0] d[$]);
        int padded;
        padded = ((len + N - 1) / N) * N;
        for (int k = 0; k < padded; k++) begin
            exp_q.push_back({(k < len) ? d[k] : 32'd0, ((k % N) == N - 1)});
        end
        m_frames = m_frames + 16'(padded / N);
        if ((len % N) != 0) m_pads = m_pads + 16'd1;
    endtask

    task automatic send_sample(input logic [31:0] d, input logic last, input bit gaps);
        int guard;
        guard = 0;
        while (gaps && ($urandom_range(0, 3) == 0)) begin
            s_axis_tvalid = 1'b0;
            @(posedge aclk);
            #1;
        end
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        @(negedge aclk);
        while (!s_axis_tready && guard < 500) begin
            @(negedge aclk);
            guard++;
        end
        if (guard >= 500) begin
            total++;
            bad++;
            $display("FAIL input accept timeout actual=tready0 required=tready1");
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_transfer(input int len, input logic [31:0] base, input bit gaps, input bit rnd);
        logic [31:0] d[$];
        for (int i = 0; i < len; i++) d.push_back(rnd ? $urandom : base + 32'(i));
        model_transfer(len, d);
        @(posedge aclk);
        #1;
        for (int i = 0; i < len; i++) send_sample(d[i], (i == len - 1), gaps);
    endtask

    task automatic drain_and_check(input string name);
        int    guard;
        int    n;
        beat_t g;
        beat_t e;
        guard = 0;
        while (got_q.size() < exp_q.size() && guard < 3000) begin
            @(negedge aclk);
            guard++;
        end
        @(negedge aclk);
        chk_eq({name, " beats"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = 0;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk_eq($sformatf("%s beat%0d data", name, n), g.data, e.data);
            chk_eq($sformatf("%s beat%0d last", name, n), 32'(g.last), 32'(e.last));
            n++;
        end
        got_q.delete();
        exp_q.delete();
        chk_eq({name, " frame_cnt"}, 32'(frame_cnt), 32'(m_frames));
        chk_eq({name, " pad_cnt"}, 32'(pad_cnt), 32'(m_pads));
        chk_eq({name, " busy idle"}, 32'(busy), 32'd0);
        chk_eq({name, " valid idle"}, 32'(m_axis_tvalid), 32'd0);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        got_q.delete();
        exp_q.delete();
        hs_cyc_q.delete();
        m_frames = 16'd0;
        m_pads   = 16'd0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int   tab_frames;
        int   tab_pads;
        int   guard;

        tbl[0] = '{16, 32'h1,  2, 0};
        tbl[1] = '{5,  32'hA0, 1, 1};
        tbl[2] = '{1,  32'h55, 1, 1};
        tbl[3] = '{8,  32'h60, 1, 0};
        tbl[4] = '{9,  32'h70, 2, 1};
        tbl[5] = '{7,  32'h80, 1, 1};

        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        aresetn       = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk_eq("rst valid", 32'(m_axis_tvalid), 32'd0);
        chk_eq("rst last", 32'(m_axis_tlast), 32'd0);
        chk_eq("rst data", m_axis_tdata, 32'd0);
        chk_eq("rst frame_cnt", 32'(frame_cnt), 32'd0);
        chk_eq("rst pad_cnt", 32'(pad_cnt), 32'd0);
        chk_eq("rst busy", 32'(busy), 32'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        chk_eq("post-rst tready", 32'(s_axis_tready), 32'd1);

        // Table of transfers under random valid/ready.
        rdy_mode   = 0;
        tab_frames = 0;
        tab_pads   = 0;
        for (int v = 0; v < 6; v++) begin
            send_transfer(tbl[v].len, tbl[v].base, 1'b1, 1'b0);
            tab_frames += tbl[v].exp_frames;
            tab_pads   += tbl[v].exp_pads;
            drain_and_check($sformatf("tbl%0d", v));
            chk_eq($sformatf("tbl%0d frames", v), 32'(frame_cnt), 32'(tab_frames));
            chk_eq($sformatf("tbl%0d pads", v), 32'(pad_cnt), 32'(tab_pads));
        end

        // Downstream stall of ten cycles mid-transfer.
        rdy_mode = 2;
        fork
            send_transfer(8, 32'h200, 1'b0, 1'b0);
            begin
                repeat (12) @(posedge aclk);
                rdy_mode = 1;
            end
        join
        drain_and_check("backpressure");

        // Full throughput with continuous ready.
        rdy_mode = 1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        hs_cyc_q.delete();
        send_transfer(16, 32'h100, 1'b0, 1'b0);
        drain_and_check("throughput");
        chk_eq("throughput count", 32'(hs_cyc_q.size()), 32'd16);
        if (hs_cyc_q.size() == 16) begin
            chk_eq("throughput span", hs_cyc_q[15] - hs_cyc_q[0], 32'd15);
        end

        // Reset asserted after two pad zeros have been consumed.
        send_transfer(3, 32'h300, 1'b0, 1'b0);
        guard = 0;
        while (got_q.size() < 5 && guard < 200) begin
            @(negedge aclk);
            guard++;
        end
        chk_eq("midpad reached", 32'(got_q.size() >= 5), 32'd1);
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        chk_eq("midpad rst valid", 32'(m_axis_tvalid), 32'd0);
        chk_eq("midpad rst frame_cnt", 32'(frame_cnt), 32'd0);
        chk_eq("midpad rst pad_cnt", 32'(pad_cnt), 32'd0);
        chk_eq("midpad rst busy", 32'(busy), 32'd0);
        do_reset();
        @(posedge aclk);
        @(negedge aclk);
        chk_eq("midpad post tready", 32'(s_axis_tready), 32'd1);
        send_transfer(8, 32'h400, 1'b0, 1'b0);
        drain_and_check("after midpad rst");

        // Frame counter wrap from a preloaded 65535.
        @(posedge aclk);
        #1;
        force dut.frame_cnt_q = 16'hFFFF;
        @(posedge aclk);
        #1;
        release dut.frame_cnt_q;
        m_frames = 16'hFFFF;
        @(negedge aclk);
        chk_eq("wrap preload", 32'(frame_cnt), 32'hFFFF);
        rdy_mode = 0;
        send_transfer(8, 32'h500, 1'b1, 1'b0);
        drain_and_check("wrap");
        chk_eq("wrap frame_cnt zero", 32'(frame_cnt), 32'd0);

        // Random transfers, random data, random valid/ready.
        for (int t = 0; t < 30; t++) begin
            send_transfer($urandom_range(1, 20), 32'd0, 1'b1, 1'b1);
        end
        drain_and_check("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_frame_aligner.md
# fft_frame_aligner

Framing stage placed directly upstream of the FFT core in the speech-classification pipeline. It runs in the 100 MHz processing domain, between the host-receive width converter and the FFT data input. It accepts an arbitrary-length complex sample stream whose `tlast` marks the end of a host transfer. It emits frames of exactly `FFT_LEN` samples with `tlast` on the final sample, zero-padding any frame that a host `tlast` cuts short.

## Interface
Parameters:
- `FFT_LEN`, default 1024: samples per output frame; power of two, 8..65536.
- `DATA_W`, default 32: sample width; `{imag[31:16], real[15:0]}` at the default.

Ports:
- `aclk`  in  1  clock; the only clock.
- `aresetn`  in  1  reset, synchronous, active-low.
- `s_axis_tdata`  in  DATA_W  input sample.
- `s_axis_tvalid`  in  1  input valid.
- `s_axis_tready`  out  1  input ready.
- `s_axis_tlast`  in  1  end of host transfer.
- `m_axis_tdata`  out  DATA_W  output sample (FFT input).
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  output ready.
- `m_axis_tlast`  out  1  last sample of an FFT frame.
- `frame_cnt`  out  16  frames emitted; wraps at 2^16.
- `pad_cnt`  out  16  frames that needed padding; wraps at 2^16.
- `busy`  out  1  high while a frame is partially emitted.

## Operation
- `idx`: log2(FFT_LEN)-bit counter holding the output position in the current frame. It is incremented only on an output handshake (`m_axis_tvalid && m_axis_tready`) and wraps from FFT_LEN-1 to 0.
- State machine with two states:
  - PASS (reset state): input samples are forwarded one for one.
  - PAD: zeros are generated; the input is stalled.
- PASS:
  - Input is accepted when the output register is free.
  - The forwarded sample gets `m_axis_tlast = (idx == FFT_LEN-1)`.
  - If the accepted sample has `s_axis_tlast` set and `idx != FFT_LEN-1`, the state goes to PAD.
  - If `s_axis_tlast` coincides with `idx == FFT_LEN-1`, the state stays in PASS and no padding occurs.
  - If the input runs past FFT_LEN samples without a `tlast`, the next frame starts with no gap.
- PAD:
  - `s_axis_tready` = 0.
  - Each cycle the output register is free, one `m_axis_tdata` = 0 is emitted.
  - `m_axis_tlast` is set on the zero at `idx == FFT_LEN-1`; that handshake returns the state to PASS.
- Counters:
  - `frame_cnt` increments on every handshake with `m_axis_tlast`.
  - `pad_cnt` increments when PASS→PAD is taken.
- `busy` = (`idx != 0`) || `m_axis_tvalid`.
- The sample data itself is never modified; only zeros are inserted.

## Timing
- Output is a single register stage; latency from input handshake to `m_axis_tvalid` is 1 cycle.
- `s_axis_tready` = (state == PASS) && (!`m_axis_tvalid` || `m_axis_tready`), combinational. Full throughput is 1 sample/cycle under continuous ready.
- The output register holds `tdata`, `tlast` and `tvalid` stable until a handshake occurs (AXI-Stream rule).
- Input is accepted only on the handshake cycle, not when `tvalid` alone is high.
- The first padding zero appears the cycle after the short sample's output handshake frees the register. There is no bubble: a pad zero is loaded in the same cycle the last real sample is consumed downstream.
- Reset values: `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tdata`, `frame_cnt`, `pad_cnt`, `idx`, `busy` = 0; state = PASS; `s_axis_tready` = 1 one cycle after `aresetn` is released.
- Reset asserted mid-frame or mid-pad: everything above clears on the next `aclk` edge. The partial frame is discarded and not completed.
- A `tlast` on the very first sample of a frame (`idx` = 0) yields 1 data sample followed by FFT_LEN-1 zeros.

## Test plan
All scenarios use `FFT_LEN` = 8 with random valid/ready unless stated.
- Aligned transfer: 16 samples 1..16, `tlast` on 16 → two frames; `tlast` on output samples 8 and 16; `frame_cnt` = 2; `pad_cnt` = 0; no zeros inserted.
- Short transfer: 5 samples A..E, `tlast` on E → output A,B,C,D,E,0,0,0 with `tlast` on the 8th; `s_axis_tready` low for 3 accepted pad cycles; `pad_cnt` = 1.
- Single-sample transfer, then 8 more samples with `tlast` → output X,0×7 (`tlast`), then 8 samples (`tlast`); `frame_cnt` = 2, `pad_cnt` = 1.
- Backpressure: `m_axis_tready` held low for 10 cycles mid-frame → `m_axis_tdata`/`tlast` stable, no sample lost or duplicated; with continuous ready, throughput is exactly 1/cycle.
- Reset mid-pad: assert `aresetn` = 0 after 2 pad zeros → next edge gives `m_axis_tvalid` = 0, counters = 0, state PASS; a fresh 8-sample transfer emits cleanly with `tlast` on sample 8.
- Counter wrap: preload 65535 frames (or force) → next frame gives `frame_cnt` = 0.
